manycore_eva_npa_xlate: RTL and testbench

// - Translates a 32-bit core effective virtual address (EVA) into a network physical address:

---
 rtl/manycore_eva_npa_xlate.sv | 150 +++++++++++++++
 tb/tb_manycore_eva_npa_xlate.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/manycore_eva_npa_xlate.sv
// manycore_eva_npa_xlate
// Maps a 32-bit core effective virtual address onto a network destination:
// a tile coordinate {pod, sub} plus a word address inside that tile. There
// are three regions: DRAM, hashed across the vcache banks north and south of
// the pod; global tile; and tile-group, which is relative to the group origin.
// Any other EVA is flagged invalid, and all translated outputs are then zero.
// Optional feature: define EVA_NPA_OUT_REG_EN to register all four outputs
// (one cycle of latency, synchronous active-high reset). Without it, the
// block is purely combinational and clk_i/reset_i are ignored.
module manycore_eva_npa_xlate #(
  parameter int data_width_p                 = 32,
  parameter int addr_width_p                 = 16,
  parameter int x_cord_width_p               = 6,
  parameter int y_cord_width_p               = 6,
  parameter int pod_x_cord_width_p           = 2,
  parameter int pod_y_cord_width_p           = 2,
  parameter int epa_byte_addr_width_p        = 18,
  parameter int num_tiles_x_p                = 16,
  parameter int num_tiles_y_p                = 8,
  parameter int num_vcache_rows_p            = 1,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int vcache_size_p                = 4096,
  parameter int vcache_sets_p                = 64
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  input  logic [31:0]                                      eva_i,
  input  logic [x_cord_width_p-pod_x_cord_width_p-1:0]     tgo_x_i,
  input  logic [y_cord_width_p-pod_y_cord_width_p-1:0]     tgo_y_i,
  input  logic [pod_x_cord_width_p-1:0]                    pod_x_i,
  input  logic [pod_y_cord_width_p-1:0]                    pod_y_i,
  output logic [x_cord_width_p-1:0]                        x_cord_o,
  output logic [y_cord_width_p-1:0]                        y_cord_o,
  output logic [addr_width_p-1:0]                          epa_o,
  output logic                                             is_invalid_addr_o
);

  localparam int XS  = x_cord_width_p - pod_x_cord_width_p;
  localparam int YS  = y_cord_width_p - pod_y_cord_width_p;
  localparam int PY  = pod_y_cord_width_p;
  localparam int E   = epa_byte_addr_width_p;
  localparam int WO  = $clog2(vcache_block_size_in_words_p);
  localparam int LGX = $clog2(num_tiles_x_p);
  localparam int LGR = $clog2(num_vcache_rows_p);
  // Bit position of the first DRAM index bit above the bank-select fields.
  localparam int IDX_LO = WO + LGX + 1 + LGR;
  localparam int XW1 = XS + 1;
  localparam int YW1 = YS + 1;

  // Catch illegal parameter combinations at elaboration time.
  if (vcache_size_p % (vcache_sets_p * vcache_block_size_in_words_p) != 0) begin : g_bad_vcache
    $error("vcache_size_p must be a multiple of vcache_sets_p * block size");
  end
  if (epa_byte_addr_width_p + x_cord_width_p + y_cord_width_p > 30) begin : g_bad_widths
    $error("global EVA fields exceed the 30-bit address payload");
  end
  if (data_width_p != 32) begin : g_bad_data_width
    $error("data_width_p must be 32");
  end

  // Word address: the byte offset is dropped, and bit 31 selects the region.
  logic [28:0] w;
  assign w = eva_i[30:2];

  // The two low byte-offset bits never influence routing, and the clock and
  // reset are only used when the output register is built.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk_i, reset_i, eva_i[1:0]};

  // DRAM bank hashing fields
  logic [XS-1:0]  dram_bx;
  logic           dram_bs;
  logic [YS-1:0]  dram_br;
  logic [28:0]    dram_idx;
  // Tile-group sums, one bit wider so that overflow is seen as out of range
  logic [XW1-1:0] tg_sx;
  logic [YW1-1:0] tg_sy;
  // Shared byte-offset word address of the global and tile-group regions
  logic [addr_width_p-1:0] tile_epa;

  assign dram_bx  = XS'((w >> WO) & 29'(num_tiles_x_p - 1));
  assign dram_bs  = w[WO+LGX];
  assign dram_br  = YS'((w >> (WO + LGX + 1)) & 29'(num_vcache_rows_p - 1));
  assign dram_idx = ((w >> IDX_LO) << WO) | (w & 29'(vcache_block_size_in_words_p - 1));

  assign tg_sx    = XW1'(tgo_x_i) + XW1'(eva_i[E +: XS]);
  assign tg_sy    = YW1'(tgo_y_i) + YW1'(eva_i[E+XS +: YS]);

  assign tile_epa = addr_width_p'((eva_i & ((32'd1 << E) - 32'd1)) >> 2);

  logic [x_cord_width_p-1:0] x_nxt;
  logic [y_cord_width_p-1:0] y_nxt;
  logic [addr_width_p-1:0]   epa_nxt;
  logic                      inv_nxt;

  // Region decode and per-region coordinate selection; invalid forces zeros
  always_comb begin
    x_nxt   = '0;
    y_nxt   = '0;
    epa_nxt = '0;
    inv_nxt = 1'b0;
    if (eva_i[31]) begin
      x_nxt   = {pod_x_i, dram_bx};
      // North banks count down from the bottom row of the pod above.
      if (dram_bs) y_nxt = {pod_y_i + PY'(1), dram_br};
      else         y_nxt = {pod_y_i - PY'(1), YS'((2 ** YS) - 1) - dram_br};
      epa_nxt = addr_width_p'(dram_idx);
      inv_nxt = (dram_idx >= 29'(vcache_size_p));
    end else if (eva_i[30]) begin
      x_nxt   = eva_i[E +: x_cord_width_p];
      y_nxt   = eva_i[E+x_cord_width_p +: y_cord_width_p];
      epa_nxt = tile_epa;
    end else if (eva_i[29]) begin
      x_nxt   = {pod_x_i, XS'(tg_sx)};
      y_nxt   = {pod_y_i, YS'(tg_sy)};
      epa_nxt = tile_epa;
      inv_nxt = (tg_sx >= XW1'(num_tiles_x_p)) || (tg_sy >= YW1'(num_tiles_y_p));
    end else begin
      inv_nxt = 1'b1;
    end
    if (inv_nxt) begin
      x_nxt   = '0;
      y_nxt   = '0;
      epa_nxt = '0;
    end
  end

`ifdef EVA_NPA_OUT_REG_EN
  // Output register: one cycle of latency; reset clears every output
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_cord_o          <= '0;
      y_cord_o          <= '0;
      epa_o             <= '0;
      is_invalid_addr_o <= 1'b0;
    end else begin
      x_cord_o          <= x_nxt;
      y_cord_o          <= y_nxt;
      epa_o             <= epa_nxt;
      is_invalid_addr_o <= inv_nxt;
    end
  end
`else
  assign x_cord_o          = x_nxt;
  assign y_cord_o          = y_nxt;
  assign epa_o             = epa_nxt;
  assign is_invalid_addr_o = inv_nxt;
`endif

endmodule

// File: tb/tb_manycore_eva_npa_xlate.sv
// Testbench for manycore_eva_npa_xlate: directed address-map cases plus
// randomized EVAs in each region, checked against an arithmetic model.
// Builds in either output mode (EVA_NPA_OUT_REG_EN defined or not).
module tb_manycore_eva_npa_xlate;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] eva = '0;
  logic [3:0]  tgo_x = '0;
  logic [3:0]  tgo_y = '0;
  logic [1:0]  pod_x = 2'd1;
  logic [1:0]  pod_y = 2'd1;
  logic [5:0]  x_cord;
  logic [5:0]  y_cord;
  logic [15:0] epa;
  logic        invalid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  manycore_eva_npa_xlate dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .eva_i             (eva),
    .tgo_x_i           (tgo_x),
    .tgo_y_i           (tgo_y),
    .pod_x_i           (pod_x),
    .pod_y_i           (pod_y),
    .x_cord_o          (x_cord),
    .y_cord_o          (y_cord),
    .epa_o             (epa),
    .is_invalid_addr_o (invalid)
  );

  // Address-map model for the default parameter set; result packed as
  // {x[5:0], y[5:0], epa[15:0], invalid}.
  function automatic logic [28:0] model(input logic [31:0] a, input int tx, input int ty,
                                        input int px, input int py);
    int x, y, e, word, o, bx, bs, br, idx, sx, sy;
    bit inv;
    x = 0; y = 0; e = 0; inv = 0;
    if (a[31]) begin
      word = int'(a[30:2]);
      o    = word % 8;
      bx   = (word / 8) % 16;
      bs   = (word / 128) % 2;
      br   = (word / 256) % 1;
      idx  = (word / 256) * 8 + o;
      x    = px * 16 + bx;
      if (bs == 0) y = ((py + 3) % 4) * 16 + (15 - br);
      else         y = ((py + 1) % 4) * 16 + br;
      e    = idx % 65536;
      inv  = (idx >= 4096);
    end else if (a[31:30] == 2'b01) begin
      x = int'((a >> 18) % 64);
      y = int'((a >> 24) % 64);
      e = int'((a % 262144) / 4);
    end else if (a[31:29] == 3'b001) begin
      sx  = tx + int'((a >> 18) % 16);
      sy  = ty + int'((a >> 22) % 16);
      inv = (sx >= 16) || (sy >= 8);
      x   = px * 16 + sx;
      y   = py * 16 + sy;
      e   = int'((a % 262144) / 4);
    end else begin
      inv = 1;
    end
    if (inv) begin
      x = 0; y = 0; e = 0;
    end
    return {6'(x), 6'(y), 16'(e), inv};
  endfunction

  // Wait until the outputs reflect the inputs just driven.
  task automatic settle();
`ifdef EVA_NPA_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic drive(input logic [31:0] a, input logic [3:0] tx, input logic [3:0] ty,
                       input logic [1:0] px, input logic [1:0] py);
    eva = a; tgo_x = tx; tgo_y = ty; pod_x = px; pod_y = py;
  endtask

  task automatic test_reset();
    logic [28:0] exp_v;
    @(posedge clk); #1;
    drive(32'h4A4C_0008, 4'd0, 4'd0, 2'd1, 2'd1);
    reset = 1'b1;
    settle();
`ifdef EVA_NPA_OUT_REG_EN
    exp_v = '0;
`else
    exp_v = {6'h13, 6'h0A, 16'h0002, 1'b0};
`endif
    vectors++;
    if ({x_cord, y_cord, epa, invalid} !== exp_v) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", {x_cord, y_cord, epa, invalid}, exp_v);
    end
    reset = 1'b0;
    settle();
    exp_v = {6'h13, 6'h0A, 16'h0002, 1'b0};
    vectors++;
    if ({x_cord, y_cord, epa, invalid} !== exp_v) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", {x_cord, y_cord, epa, invalid}, exp_v);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [3:0]  tx, ty;
    logic [1:0]  px, py;
    logic [28:0] exp_v;
  } dvec_t;

  task automatic test_directed();
    dvec_t t[8];
    t[0] = '{32'h2044_0010, 4'd1,  4'd2, 2'd1, 2'd1, {6'h12, 6'h13, 16'h0004, 1'b0}};
    t[1] = '{32'h2044_0010, 4'd15, 4'd2, 2'd1, 2'd1, {6'h00, 6'h00, 16'h0000, 1'b1}};
    t[2] = '{32'h4A4C_0008, 4'd0,  4'd0, 2'd1, 2'd1, {6'h13, 6'h0A, 16'h0002, 1'b0}};
    t[3] = '{32'h8000_0020, 4'd0,  4'd0, 2'd1, 2'd1, {6'h11, 6'h0F, 16'h0000, 1'b0}};
    t[4] = '{32'h8000_020C, 4'd0,  4'd0, 2'd1, 2'd1, {6'h10, 6'h20, 16'h0003, 1'b0}};
    t[5] = '{32'hC000_0000, 4'd0,  4'd0, 2'd1, 2'd1, {6'h00, 6'h00, 16'h0000, 1'b1}};
    t[6] = '{32'h0000_1000, 4'd0,  4'd0, 2'd1, 2'd1, {6'h00, 6'h00, 16'h0000, 1'b1}};
    t[7] = '{32'h8000_0000, 4'd0,  4'd0, 2'd1, 2'd0, {6'h10, 6'h3F, 16'h0000, 1'b0}};
    for (int i = 0; i < 8; i++) begin
      drive(t[i].a, t[i].tx, t[i].ty, t[i].px, t[i].py);
      settle();
      vectors++;
      if ({x_cord, y_cord, epa, invalid} !== t[i].exp_v) begin
        miscompares++;
        $display("FAIL directed_%0d eva=%h: got %h expected %h", i, t[i].a,
                 {x_cord, y_cord, epa, invalid}, t[i].exp_v);
      end
    end
  endtask

  // region: 0 dram (mostly in range), 1 global, 2 tile-group, 3 local, 4 any
  task automatic test_region(input int region, input int count, input string name);
    logic [31:0] a;
    logic [28:0] exp_v;
    for (int i = 0; i < count; i++) begin
      a = $urandom;
      case (region)
        0: a = (i % 4 == 3) ? {1'b1, a[30:0]} : {13'h1000, a[18:0]};
        1: a = {2'b01, a[29:0]};
        2: a = {3'b001, a[28:0]};
        3: a = {3'b000, a[28:0]};
        default: ;
      endcase
      drive(a, 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom));
      exp_v = model(eva, int'(tgo_x), int'(tgo_y), int'(pod_x), int'(pod_y));
      settle();
      vectors++;
      if ({x_cord, y_cord, epa, invalid} !== exp_v) begin
        miscompares++;
        $display("FAIL %s eva=%h tgo=%0d,%0d pod=%0d,%0d: got %h expected %h", name, a,
                 tgo_x, tgo_y, pod_x, pod_y, {x_cord, y_cord, epa, invalid}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_region(0, 60, "dram");
    test_region(1, 40, "global");
    test_region(2, 60, "tile_group");
    test_region(3, 20, "local");
    test_region(4, 80, "back_to_back");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
